// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: RAM handshake states, arbiter FSM states
// and the index-width helper.
package ram_arbiter_pkg;

  localparam int unsigned ARB_NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Index width that stays >= 1 even for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side request bus plus the single RAM port, seen from the arbiter (master)
// and from the requesters/RAM side (slave).
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ_DEFAULT,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);

  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_store;
  logic [NREQ-1:0]    req_wait;
  logic [DW-1:0]      req_load;

  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  ramstate_t          ramstate;

  modport master (
    input  req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output req_ren, req_wen, req_lock, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, wrapping modulo NREQ.
// Purely combinational so it can be shared with the coherence controller.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = ARB_NREQ_DEFAULT,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  // Explicit compare keeps non-power-of-two NREQ correct.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[wrap_add(i_ptr, k)]) begin
        o_idx   = wrap_add(i_ptr, k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of NREQ cache requesters onto one RAM port; holds the grant
// across locked bursts. Optional per-requester counters under `ARB_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ_DEFAULT,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  ram_arbiter_if.master       bus
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]  stat_grants,
  output logic [NREQ*32-1:0]  stat_waitcyc
`endif
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = 32;

  arb_state_t     r_state, w_state_nxt;
  logic [IW-1:0]  r_owner, w_owner_nxt;
  logic [IW-1:0]  r_rr_ptr, w_rr_ptr_nxt;

  logic [NREQ-1:0] w_req;
  logic [IW-1:0]   w_win;
  logic            w_win_vld;
  logic            w_grant;
  logic            w_done;
  logic [AW-1:0]   w_addr  [NREQ];
  logic [DW-1:0]   w_store [NREQ];

  assign w_req   = bus.req_ren | bus.req_wen;
  assign w_done  = (bus.ramstate == ACCESS);
  assign w_grant = (r_state == ARB_IDLE) && w_win_vld;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_addr[g]  = bus.req_addr[g*AW +: AW];
    assign w_store[g] = bus.req_store[g*DW +: DW];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Release only when the owner is neither requesting nor holding its lock.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ARB_OWNED;
          w_owner_nxt = w_win;
        end
      end
      ARB_OWNED: begin
        if (!w_req[r_owner] && !bus.req_lock[r_owner]) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = (32'(r_owner) == NREQ - 1) ? '0 : r_owner + IW'(1);
        end
      end
    endcase
  end

  // Write wins over read; ERROR is not ACCESS, so the owner keeps waiting.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.req_wait = w_req;
    bus.req_load = bus.ramload;
    if (r_state == ARB_OWNED) begin
      bus.ramWEN            = bus.req_wen[r_owner];
      bus.ramREN            = bus.req_ren[r_owner] & ~bus.req_wen[r_owner];
      bus.ramaddr           = w_addr[r_owner];
      bus.ramstore          = w_store[r_owner];
      bus.req_wait[r_owner] = w_req[r_owner] & ~w_done;
    end
  end

`ifdef ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [CW-1:0] r_grants;
    logic [CW-1:0] r_waitcyc;

    // Saturating counters.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_grants  <= '0;
        r_waitcyc <= '0;
      end else begin
        if (w_grant && (w_win == IW'(g)) && (r_grants != '1))
          r_grants <= r_grants + CW'(1);
        if (bus.req_wait[g] && (r_waitcyc != '1))
          r_waitcyc <= r_waitcyc + CW'(1);
      end
    end

    assign stat_grants[g*CW +: CW]  = r_grants;
    assign stat_waitcyc[g*CW +: CW] = r_waitcyc;
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-requester op queues feed a driver, a RAM
// model answers, and a monitor checks every completed access against expectations.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;

  typedef struct {
    logic          ren;
    logic          wen;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [NREQ*32-1:0] stat_grants;
  logic [NREQ*32-1:0] stat_waitcyc;
`endif

  ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_waitcyc (stat_waitcyc)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM model: access completes once a strobe has been held for lat cycles.
  logic [DW-1:0] mem [64];
  int unsigned   lat;
  logic          err_inj;
  logic [3:0]    r_cnt;
  logic          w_strobe;

  assign w_strobe    = bus.ramREN | bus.ramWEN;
  assign bus.ramload = mem[bus.ramaddr[7:2]];

  always_comb begin
    if (!w_strobe)               bus.ramstate = FREE;
    else if (err_inj)            bus.ramstate = ERROR;
    else if (32'(r_cnt) >= lat)  bus.ramstate = ACCESS;
    else                         bus.ramstate = BUSY;
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA000_0000 | 32'(k * 4);
      r_cnt <= '0;
    end else begin
      if (bus.ramstate == ACCESS && bus.ramWEN) mem[bus.ramaddr[7:2]] <= bus.ramstore;
      if (!w_strobe || bus.ramstate == ACCESS) r_cnt <= '0;
      else                                     r_cnt <= r_cnt + 4'd1;
    end
  end

  // Requester driver
  op_t  op_q [NREQ][$];
  op_t  cur  [NREQ];
  bit   cur_v  [NREQ];
  bit   done_s [NREQ];
  bit   flush = 1'b0;
  exp_t exp_q [$];

  always begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ren[i]            = cur_v[i] & cur[i].ren;
      bus.req_wen[i]            = cur_v[i] & cur[i].wen;
      bus.req_lock[i]           = cur_v[i] & cur[i].lock;
      bus.req_addr[i*AW +: AW]  = cur_v[i] ? cur[i].addr : '0;
      bus.req_store[i*DW +: DW] = cur_v[i] ? cur[i].data : '0;
    end
    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) done_s[i] = cur_v[i] && !bus.req_wait[i];
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (flush) begin
        op_q[i].delete();
        cur_v[i] = 1'b0;
      end else if (done_s[i]) begin
        if (cur[i].lock && op_q[i].size() > 0) cur[i] = op_q[i].pop_front();
        else cur_v[i] = 1'b0;
      end else if (!cur_v[i] && op_q[i].size() > 0) begin
        cur[i]   = op_q[i].pop_front();
        cur_v[i] = 1'b1;
      end
    end
  end

  task automatic issue(input int i, input logic ren, input logic wen, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW-1:0] expd, input bit track);
    op_t  o;
    exp_t e;
    o.ren = ren; o.wen = wen; o.lock = lock; o.addr = addr; o.data = data;
    op_q[i].push_back(o);
    if (track) begin
      e.idx = i; e.wr = wen; e.addr = addr; e.data = wen ? data : expd;
      exp_q.push_back(e);
    end
  endtask

  task automatic rd(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] expd);
    issue(i, 1'b1, 1'b0, 1'b0, addr, '0, expd, 1'b1);
  endtask

  task automatic wr(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic lock);
    issue(i, 1'b0, 1'b1, lock, addr, data, '0, 1'b1);
  endtask

  // Monitor: every served requester must match the head of the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((bus.req_ren[i] | bus.req_wen[i]) && !bus.req_wait[i]) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_completion: requester %0d addr %h expected none",
                     i, bus.ramaddr);
          end else begin
            e = exp_q.pop_front();
            chk("grant_idx", 32'(i), 32'(e.idx));
            chk("ramaddr", bus.ramaddr, e.addr);
            if (e.wr) begin
              chk("ramWEN", 32'(bus.ramWEN), 32'd1);
              chk("ramREN_on_write", 32'(bus.ramREN), 32'd0);
              chk("ramstore", bus.ramstore, e.data);
            end else begin
              chk("ramREN", 32'(bus.ramREN), 32'd1);
              chk("req_load", bus.req_load, e.data);
            end
          end
        end
      end
    end
  end

  function automatic bit drv_busy();
    for (int i = 0; i < NREQ; i++) if (cur_v[i] || op_q[i].size() > 0) return 1'b1;
    return exp_q.size() != 0;
  endfunction

  task automatic wait_quiet(input string nm);
    int n;
    n = 0;
    while (n < 300 && (drv_busy() || (bus.req_ren | bus.req_wen) != '0)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: pending=%0d expected 0", nm, exp_q.size());
    end
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    nRST    = 1'b0;
    lat     = 1;
    err_inj = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_req_wait", 32'(bus.req_wait), 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Contention 0 and 1 from rr_ptr=0
    @(posedge CLK);
    rd(0, 32'h10, 32'hA000_0010);
    rd(1, 32'h14, 32'hA000_0014);
    @(negedge CLK);
    chk("arb_latency_ren", 32'(bus.ramREN), 32'd0);
    chk("arb_latency_wait", 32'(bus.req_wait), 32'h3);
    @(negedge CLK);
    chk("cont_addr0", bus.ramaddr, 32'h10);
    chk("cont_wait1_busy", 32'(bus.req_wait[1]), 32'd1);
    @(negedge CLK);
    chk("cont_wait_access", 32'(bus.req_wait), 32'h2);
    wait_quiet("contention");
    chk("cont_rr_ptr", 32'(dut.r_rr_ptr), 32'd2);

    // Single read
    @(posedge CLK);
    rd(1, 32'h08, 32'hA000_0008);
    @(negedge CLK);
    chk("single_idle_ren", 32'(bus.ramREN), 32'd0);
    @(negedge CLK);
    chk("single_ren", 32'(bus.ramREN), 32'd1);
    chk("single_addr", bus.ramaddr, 32'h08);
    chk("single_wait_busy", 32'(bus.req_wait), 32'h2);
    @(negedge CLK);
    chk("single_wait_access", 32'(bus.req_wait), 32'h0);
    wait_quiet("single");

    // Locked burst from dcache 1 while icache 0 requests
    @(posedge CLK);
    wr(1, 32'h3C, 32'h0000_BEEF, 1'b1);
    wr(1, 32'h40, 32'h0000_DED2, 1'b1);
    @(posedge CLK);
    rd(0, 32'h44, 32'hA000_0044);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("burst_wen", 32'(bus.ramWEN), 32'd1);
      chk("burst_icache_wait", 32'(bus.req_wait[0]), 32'd1);
      if (c == 0) chk("burst_addr0", bus.ramaddr, 32'h3C);
      if (c == 2) chk("burst_addr1", bus.ramaddr, 32'h40);
    end
    wait_quiet("burst");

    // Write wins when ren and wen are both set
    @(posedge CLK);
    issue(0, 1'b1, 1'b1, 1'b0, 32'h00, 32'h1234_5678, '0, 1'b1);
    wait_quiet("wprio");

    // Readback of written words
    @(posedge CLK);
    rd(3, 32'h3C, 32'h0000_BEEF);
    rd(3, 32'h40, 32'h0000_DED2);
    rd(3, 32'h00, 32'h1234_5678);
    wait_quiet("readback");

    // ERROR keeps the owner waiting
    err_inj = 1'b1;
    @(posedge CLK);
    rd(2, 32'h20, 32'hA000_0020);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("error_wait", 32'(bus.req_wait[2]), 32'd1);
    end
    @(posedge CLK);
    #2 err_inj = 1'b0;
    wait_quiet("error");

    // Reset mid-access
    @(posedge CLK);
    issue(3, 1'b1, 1'b0, 1'b0, 32'h28, '0, '0, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.ramREN && n < 10);
    chk("midrst_owned_ren", 32'(bus.ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_async_ren", 32'(bus.ramREN), 32'd0);
    chk("midrst_wait", 32'(bus.req_wait), 32'h8);
    flush = 1'b1;
    @(posedge CLK);
    #2 flush = 1'b0;
    @(negedge CLK);
    chk("midrst_wait_idle", 32'(bus.req_wait), 32'h0);
    chk("midrst_state", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("midrst_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
`ifdef ARB_STATS_EN
    chk("stat_rst_grants2", stat_grants[2*32 +: 32], 32'd0);
    chk("stat_rst_waitcyc3", stat_waitcyc[3*32 +: 32], 32'd0);
`endif
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // rr_ptr restarts at 0: requester 0 beats 3
    @(posedge CLK);
    rd(0, 32'h04, 32'hA000_0004);
    rd(3, 32'h0C, 32'hA000_000C);
    wait_quiet("post_reset");

    // Three grants to requester 2 with 2+2+1 wait cycles
    @(posedge CLK);
    rd(2, 32'h2C, 32'hA000_002C);
    rd(2, 32'h30, 32'hA000_0030);
    wait_quiet("stats_a");
    lat = 0;
    @(posedge CLK);
    rd(2, 32'h34, 32'hA000_0034);
    wait_quiet("stats_b");
    lat = 1;
`ifdef ARB_STATS_EN
    chk("stat_grants2", stat_grants[2*32 +: 32], 32'd3);
    chk("stat_waitcyc2", stat_waitcyc[2*32 +: 32], 32'd5);
    chk("stat_grants0", stat_grants[0 +: 32], 32'd1);
`endif

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
